// File: rtl/ay_shadow_if.sv
// PSG bus snoop interface: registered BC1/BDIR strobes and CPU data in,
// shadow readback and chip/address status out.
interface ay_shadow_if;
  // Strobe semantics: a command is taken once, on the first cycle ay_bdir is
  // seen high (bc1=1 latch, bc1=0 write). Holding ay_bdir high or changing
  // ay_bc1 under it adds nothing. Readback is live whenever bc1=1 and bdir=0.
  logic       ay_bc1;
  logic       ay_bdir;
  logic [7:0] d;
  logic [7:0] d_out;
  logic       d_out_active;
  logic       chip_sel;
  logic [3:0] reg_addr;
  logic       addr_valid;
  logic       env_restart;

  modport master (
    output ay_bc1, ay_bdir, d,
    input  d_out, d_out_active, chip_sel, reg_addr, addr_valid, env_restart
  );

  modport slave (
    input  ay_bc1, ay_bdir, d,
    output d_out, d_out_active, chip_sel, reg_addr, addr_valid, env_restart
  );
endinterface

// File: rtl/ay_shadow.sv
// Shadow copy of the AY/YM register file (one or two TurboSound chips),
// driven by snooping the PSG bus strobes; supplies CPU readback data.
module ay_shadow #(
  parameter int TS_CHIPS = 2
) (
  input  logic        clk28,
  input  logic        rst_n,
  input  logic        en,
  input  logic        ts_en,
  ay_shadow_if.slave  bus
);

  localparam bit TS_DUAL = (TS_CHIPS == 2);
  localparam int NREGS   = 16 * TS_CHIPS;
  localparam int IDX_W   = TS_DUAL ? 5 : 4;

  logic [7:0]       shadow [NREGS];
  logic [7:0]       addr;
  logic             sel_q;
  logic             prev_bdir;
  logic             env_q;
  logic             cmd_start;
  logic             ts_cmd;
  logic             addr_ok;
  logic [IDX_W-1:0] idx;

  function automatic logic [7:0] width_mask(input logic [3:0] r);
    case (r)
      4'd1, 4'd3, 4'd5, 4'd13:  width_mask = 8'h0F;
      4'd6, 4'd8, 4'd9, 4'd10:  width_mask = 8'h1F;
      default:                  width_mask = 8'hFF;
    endcase
  endfunction

  generate
    if (TS_DUAL) begin : g_dual
      assign idx = {sel_q, addr[3:0]};
    end else begin : g_single
      assign idx = addr[3:0];
    end
  endgenerate

  assign cmd_start = en & bus.ay_bdir & ~prev_bdir;
  assign ts_cmd    = TS_DUAL & ts_en;
  assign addr_ok   = (addr[7:4] == 4'h0);

  // prev_bdir resets high so a bdir already asserted at reset release
  // cannot be mistaken for a fresh command edge.
  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      prev_bdir <= 1'b1;
      addr      <= 8'h00;
      sel_q     <= 1'b0;
      env_q     <= 1'b0;
      for (int i = 0; i < NREGS; i++) shadow[i] <= 8'h00;
    end else begin
      prev_bdir <= bus.ay_bdir;
      env_q     <= 1'b0;
      if (cmd_start) begin
        if (bus.ay_bc1) begin
          if (ts_cmd && bus.d == 8'hFF)      sel_q <= 1'b0;
          else if (ts_cmd && bus.d == 8'hFE) sel_q <= 1'b1;
          else                               addr  <= bus.d;
        end else if (addr_ok) begin
          shadow[idx] <= bus.d & width_mask(addr[3:0]);
          env_q       <= (addr[3:0] == 4'd13);
        end
      end
    end
  end

  assign bus.d_out        = addr_ok ? shadow[idx] : 8'hFF;
  assign bus.d_out_active = en & bus.ay_bc1 & ~bus.ay_bdir;
  assign bus.chip_sel     = sel_q;
  assign bus.reg_addr     = addr[3:0];
  assign bus.addr_valid   = addr_ok;
  assign bus.env_restart  = env_q;

endmodule
